// File: rtl/trace_buffer_pkg.sv
// Shared types and defaults for the double-buffered trace store.
package trace_buffer_pkg;

    localparam int COLUMNS_DEFAULT  = 640;
    localparam int HEIGHT_W_DEFAULT = 8;

    // One traced column: wall height plus facing (0 = EW, 1 = NS).
    typedef struct packed {
        logic [HEIGHT_W_DEFAULT-1:0] height;
        logic                        side;
    } trace_entry_t;

endpackage

// File: rtl/trace_pingpong_buffer_if.sv
// Tracer write port, renderer read port and swap handshake of the trace buffer.
interface trace_pingpong_buffer_if #(
    parameter int COL_W    = 10,
    parameter int HEIGHT_W = 8
);
    logic                wr_en;
    logic [COL_W-1:0]    wr_column;
    logic [HEIGHT_W-1:0] wr_height;
    logic                wr_side;
    logic                rd_en;
    logic [COL_W-1:0]    rd_column;
    logic [HEIGHT_W-1:0] rd_height;
    logic                rd_side;
    logic                rd_valid;
    logic                swap_req;
    logic                swap_ack;
    logic                front_bank;
    logic                back_complete;
    logic [COL_W:0]      written_count;

    // Strobes are single-cycle and never back-pressured: wr_en/rd_en/swap_req are
    // acted on at the edge they are sampled; rd_valid and swap_ack answer one cycle later.
    modport master (
        output wr_en, wr_column, wr_height, wr_side,
        output rd_en, rd_column, swap_req,
        input  rd_height, rd_side, rd_valid,
        input  swap_ack, front_bank, back_complete, written_count
    );

    modport slave (
        input  wr_en, wr_column, wr_height, wr_side,
        input  rd_en, rd_column, swap_req,
        output rd_height, rd_side, rd_valid,
        output swap_ack, front_bank, back_complete, written_count
    );
endinterface

// File: rtl/trace_bank.sv
// 1R1W synchronous RAM of trace entries with a registered read port.
module trace_bank
    import trace_buffer_pkg::*;
#(
    parameter int DEPTH  = COLUMNS_DEFAULT,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  trace_entry_t      wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output trace_entry_t      rdata
);
    trace_entry_t mem [DEPTH];

    // Storage itself is never reset so it can map onto block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end
endmodule

// File: rtl/trace_pingpong_buffer.sv
// Ping-pong trace store: tracer fills the back bank, renderer reads the front bank.
// Optional TRACEBUF_SWAP_STATS_EN adds the saturating missed_swaps counter port.
module trace_pingpong_buffer
    import trace_buffer_pkg::*;
#(
    parameter int COLUMNS  = COLUMNS_DEFAULT,
    parameter int HEIGHT_W = HEIGHT_W_DEFAULT,
    parameter int COL_W    = $clog2(COLUMNS)
) (
    input  logic                    clk,
    input  logic                    reset,
    trace_pingpong_buffer_if.slave  bus
`ifdef TRACEBUF_SWAP_STATS_EN
    ,
    output logic [7:0]              missed_swaps
`endif
);
    localparam int                 CNT_W  = COL_W + 1;
    localparam logic [CNT_W-1:0]   COLS_L = CNT_W'(COLUMNS);

    logic               front_q;
    logic               swap_ack_q;
    logic [COLUMNS-1:0] written_map;
    logic [CNT_W-1:0]   written_count_q;
    logic               rd_valid_q;
    logic               rd_sel_q;
    logic               rd_oob_q;

    logic               wr_in_range;
    logic               rd_in_range;
    logic               wr_fire;
    logic               rd_fire;
    logic               wr_new;
    logic               back_complete;
    logic               swap_accept;
    logic [1:0]         bank_we;
    logic [1:0]         bank_re;
    trace_entry_t       wr_entry;
    trace_entry_t       rd_data [2];

    assign wr_in_range   = {1'b0, bus.wr_column} < COLS_L;
    assign rd_in_range   = {1'b0, bus.rd_column} < COLS_L;
    assign wr_fire       = bus.wr_en & wr_in_range;
    assign rd_fire       = bus.rd_en & rd_in_range;
    assign back_complete = (written_count_q == COLS_L);
    assign swap_accept   = bus.swap_req & back_complete;
    assign wr_new        = wr_fire & ~written_map[bus.wr_column];
    assign wr_entry      = '{height: bus.wr_height, side: bus.wr_side};

    // Writes go to the bank not on display, reads to the displayed one.
    assign bank_we = {wr_fire & ~front_q, wr_fire & front_q};
    assign bank_re = {rd_fire & front_q, rd_fire & ~front_q};

    for (genvar b = 0; b < 2; b++) begin : g_bank
        trace_bank #(
            .DEPTH  (COLUMNS),
            .ADDR_W (COL_W)
        ) u_bank (
            .clk   (clk),
            .reset (reset),
            .we    (bank_we[b]),
            .waddr (bus.wr_column),
            .wdata (wr_entry),
            .re    (bank_re[b]),
            .raddr (bus.rd_column),
            .rdata (rd_data[b])
        );
    end

    // A write coinciding with an accepted swap lands in the new front bank,
    // so the swap clear takes priority over the bitmap update.
    always_ff @(posedge clk) begin
        if (reset) begin
            front_q         <= 1'b0;
            swap_ack_q      <= 1'b0;
            written_map     <= '0;
            written_count_q <= '0;
            rd_valid_q      <= 1'b0;
            rd_sel_q        <= 1'b0;
            rd_oob_q        <= 1'b0;
        end else begin
            swap_ack_q <= swap_accept;
            rd_valid_q <= bus.rd_en;
            if (bus.rd_en) begin
                rd_sel_q <= front_q;
                rd_oob_q <= ~rd_in_range;
            end
            if (swap_accept) begin
                front_q         <= ~front_q;
                written_map     <= '0;
                written_count_q <= '0;
            end else if (wr_new) begin
                written_map[bus.wr_column] <= 1'b1;
                written_count_q            <= written_count_q + 1'b1;
            end
        end
    end

`ifdef TRACEBUF_SWAP_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            missed_swaps <= '0;
        end else if (bus.swap_req && !back_complete && missed_swaps != 8'hFF) begin
            missed_swaps <= missed_swaps + 8'd1;
        end
    end
`endif

    // Selection and range flags only move on rd_en, so the outputs hold between reads.
    assign bus.rd_height     = rd_oob_q ? '0 : rd_data[rd_sel_q].height;
    assign bus.rd_side       = rd_oob_q ? 1'b0 : rd_data[rd_sel_q].side;
    assign bus.rd_valid      = rd_valid_q;
    assign bus.swap_ack      = swap_ack_q;
    assign bus.front_bank    = front_q;
    assign bus.back_complete = back_complete;
    assign bus.written_count = written_count_q;
endmodule

// File: tb/tb_trace_pingpong_buffer.sv
// Directed bench for trace_pingpong_buffer: table vectors plus multi-cycle sequences.
module tb_trace_pingpong_buffer;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;

    trace_pingpong_buffer_if #(.COL_W(10), .HEIGHT_W(8)) bus ();

`ifdef TRACEBUF_SWAP_STATS_EN
    logic [7:0] missed_swaps;
`endif

    trace_pingpong_buffer #(
        .COLUMNS  (640),
        .HEIGHT_W (8),
        .COL_W    (10)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef TRACEBUF_SWAP_STATS_EN
        ,
        .missed_swaps (missed_swaps)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic wr_en;
        int   wr_col;
        int   wr_h;
        logic wr_s;
        logic rd_en;
        int   rd_col;
        logic swap;
        logic chk_rd;
        logic exp_valid;
        int   exp_h;
        logic exp_s;
        logic exp_ack;
        logic exp_front;
        int   exp_cnt;
    } vec_t;

    vec_t vecs [11];

    function automatic vec_t mk(input logic we, input int wc, input int wh, input logic ws,
                                input logic re, input int rc, input logic sw, input logic cr,
                                input logic ev, input int eh, input logic es,
                                input logic ea, input logic ef, input int ec);
        vec_t v;
        v.wr_en = we; v.wr_col = wc; v.wr_h = wh; v.wr_s = ws;
        v.rd_en = re; v.rd_col = rc; v.swap = sw; v.chk_rd = cr;
        v.exp_valid = ev; v.exp_h = eh; v.exp_s = es;
        v.exp_ack = ea; v.exp_front = ef; v.exp_cnt = ec;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.wr_en = 1'b0; bus.wr_column = '0; bus.wr_height = '0; bus.wr_side = 1'b0;
        bus.rd_en = 1'b0; bus.rd_column = '0; bus.swap_req = 1'b0;
    endtask

    task automatic chk_state(input string name, input logic ack, input logic front, input int cnt);
        chk({name, ".swap_ack"}, 32'(bus.swap_ack), 32'(ack));
        chk({name, ".front_bank"}, 32'(bus.front_bank), 32'(front));
        chk({name, ".written_count"}, 32'(bus.written_count), cnt);
        chk({name, ".back_complete"}, 32'(bus.back_complete), 32'(cnt == 640));
    endtask

    task automatic chk_read(input string name, input logic valid, input int h, input logic s);
        chk({name, ".rd_valid"}, 32'(bus.rd_valid), 32'(valid));
        chk({name, ".rd_height"}, 32'(bus.rd_height), h);
        chk({name, ".rd_side"}, 32'(bus.rd_side), 32'(s));
    endtask

    // mode 0: height = col[7:0], side = col[0]; mode 1: height = (3*col)[7:0], side = col[1]
    task automatic write_range(input int lo, input int hi, input int mode,
                               input int skip_a, input int skip_b, input int skip_c);
        for (int c = lo; c <= hi; c++) begin
            if (c != skip_a && c != skip_b && c != skip_c) begin
                int v;
                v = (mode == 0) ? c : 3 * c;
                bus.wr_en     = 1'b1;
                bus.wr_column = c[9:0];
                bus.wr_height = v[7:0];
                bus.wr_side   = (mode == 0) ? c[0] : c[1];
                tick();
            end
        end
        idle();
    endtask

    task automatic read_col(input int col);
        bus.rd_en     = 1'b1;
        bus.rd_column = col[9:0];
        tick();
        idle();
    endtask

    task automatic swap();
        bus.swap_req = 1'b1;
        tick();
        idle();
    endtask

    initial begin
        vecs[0]  = mk(1, 5,   10,  0, 0, 0,   0, 0, 0, 0,   0, 0, 0, 1);
        vecs[1]  = mk(1, 5,   20,  1, 0, 0,   0, 0, 0, 0,   0, 0, 0, 1);
        vecs[2]  = mk(1, 5,   30,  1, 0, 0,   0, 0, 0, 0,   0, 0, 0, 1);
        vecs[3]  = mk(1, 700, 77,  0, 0, 0,   0, 0, 0, 0,   0, 0, 0, 1);
        vecs[4]  = mk(0, 0,   0,   0, 1, 700, 0, 1, 1, 0,   0, 0, 0, 1);
        vecs[5]  = mk(0, 0,   0,   0, 0, 0,   0, 1, 0, 0,   0, 0, 0, 1);
        vecs[6]  = mk(0, 0,   0,   0, 1, 17,  0, 1, 1, 51,  0, 0, 0, 1);
        vecs[7]  = mk(0, 0,   0,   0, 0, 0,   1, 0, 0, 0,   0, 0, 0, 1);
        vecs[8]  = mk(1, 640, 5,   0, 0, 0,   0, 0, 0, 0,   0, 0, 0, 1);
        vecs[9]  = mk(1, 639, 200, 1, 0, 0,   0, 0, 0, 0,   0, 0, 0, 2);
        vecs[10] = mk(0, 0,   0,   0, 1, 639, 0, 1, 1, 125, 1, 0, 0, 2);

        idle();
        reset = 1'b1;
        tick();
        tick();
        chk_state("reset", 0, 0, 0);
        chk_read("reset", 0, 0, 0);
`ifdef TRACEBUF_SWAP_STATS_EN
        chk("reset.missed_swaps", 32'(missed_swaps), 0);
`endif
        reset = 1'b0;

        // Full frame into bank 1, swap, read back.
        write_range(0, 639, 0, -1, -1, -1);
        chk_state("fill0", 0, 0, 640);
        swap();
        chk_state("swap0", 1, 1, 0);
        tick();
        chk("swap0.ack_drop", 32'(bus.swap_ack), 0);
        read_col(300);
        chk_read("rd300", 1, 44, 0);
        tick();
        chk_read("rd300_hold", 0, 44, 0);

        // Incomplete frame: swap rejected, then completed and accepted.
        write_range(0, 639, 1, 17, -1, -1);
        chk_state("fill_skip17", 0, 1, 639);
        swap();
        chk_state("swap_miss", 0, 1, 639);
`ifdef TRACEBUF_SWAP_STATS_EN
        chk("swap_miss.missed_swaps", 32'(missed_swaps), 1);
`endif
        write_range(17, 17, 1, -1, -1, -1);
        chk_state("fill17", 0, 1, 640);
        swap();
        chk_state("swap1", 1, 0, 0);

        for (int i = 0; i < 11; i++) begin
            bus.wr_en     = vecs[i].wr_en;
            bus.wr_column = 10'(vecs[i].wr_col);
            bus.wr_height = 8'(vecs[i].wr_h);
            bus.wr_side   = vecs[i].wr_s;
            bus.rd_en     = vecs[i].rd_en;
            bus.rd_column = 10'(vecs[i].rd_col);
            bus.swap_req  = vecs[i].swap;
            tick();
            idle();
            chk_state($sformatf("vec%0d", i), vecs[i].exp_ack, vecs[i].exp_front, vecs[i].exp_cnt);
            chk($sformatf("vec%0d.rd_valid", i), 32'(bus.rd_valid), 32'(vecs[i].exp_valid));
            if (vecs[i].chk_rd) begin
                chk_read($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_h, vecs[i].exp_s);
            end
        end
`ifdef TRACEBUF_SWAP_STATS_EN
        chk("table.missed_swaps", 32'(missed_swaps), 2);
`endif

        // Finish bank 1 around the hand-written columns, then write+read+swap together.
        write_range(0, 639, 0, 3, 5, 639);
        chk_state("fill_rest", 0, 0, 639);
        bus.wr_en = 1'b1; bus.wr_column = 10'd3; bus.wr_height = 8'd88; bus.wr_side = 1'b1;
        tick();
        idle();
        chk_state("wr3_first", 0, 0, 640);
        bus.wr_en = 1'b1; bus.wr_column = 10'd3; bus.wr_height = 8'd99; bus.wr_side = 1'b0;
        bus.rd_en = 1'b1; bus.rd_column = 10'd3; bus.swap_req = 1'b1;
        tick();
        idle();
        chk_state("same_cycle", 1, 1, 0);
        chk_read("same_cycle", 1, 9, 1);
        read_col(3);
        chk_read("rd3_new", 1, 99, 0);
        read_col(5);
        chk_read("rd5_last", 1, 30, 1);
        read_col(639);
        chk_read("rd639", 1, 200, 1);
        read_col(300);
        chk_read("rd300_b", 1, 44, 0);
        chk_state("after_reads", 0, 1, 0);

        // Mid-frame reset discards completion tracking.
        write_range(0, 319, 1, -1, -1, -1);
        chk_state("half", 0, 1, 320);
        reset = 1'b1;
        bus.rd_en = 1'b1; bus.rd_column = 10'd10;
        tick();
        idle();
        chk_state("mid_reset", 0, 0, 0);
        chk_read("mid_reset", 0, 0, 0);
`ifdef TRACEBUF_SWAP_STATS_EN
        chk("mid_reset.missed_swaps", 32'(missed_swaps), 0);
`endif
        reset = 1'b0;
        write_range(0, 639, 0, -1, -1, -1);
        chk_state("refill", 0, 0, 640);

        // Back-to-back requests: first accepted, second rejected.
        bus.swap_req = 1'b1;
        tick();
        chk_state("b2b_first", 1, 1, 0);
        tick();
        idle();
        chk_state("b2b_second", 0, 1, 0);
`ifdef TRACEBUF_SWAP_STATS_EN
        chk("b2b.missed_swaps", 32'(missed_swaps), 1);
`endif
        read_col(300);
        chk_read("rd300_c", 1, 44, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
